// File: rtl/battleship_pkg.sv
// rtl/battleship_pkg.sv - shared types and helpers for the battleship shot controller
package battleship_pkg;

  localparam int ROWS = 8;
  localparam int COLS = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PLAY,
    ST_EVAL,
    ST_WAIT_REL,
    ST_OVER
  } state_e;

  function automatic logic [5:0] CELL_IDX(input logic [2:0] r, input logic [2:0] c);
    return {r, c};
  endfunction

endpackage

// File: rtl/battleship_debounce.sv
// rtl/battleship_debounce.sv - 2-flop synchroniser plus stable-sample debouncer
module battleship_debounce #(
  parameter int DEBOUNCE_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic db,
  output logic rise
);

  localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

  logic          s1_q, s1_d;
  logic          s2_q, s2_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          db_q, db_d;
  logic          rise_q, rise_d;

  // The counter only runs while the synced level disagrees with the accepted one.
  always_comb begin
    s1_d   = din;
    s2_d   = s1_q;
    cnt_d  = '0;
    db_d   = db_q;
    rise_d = 1'b0;
    if (s2_q != db_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYC - 1)) begin
        db_d   = s2_q;
        rise_d = s2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      cnt_q  <= '0;
      db_q   <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      cnt_q  <= cnt_d;
      db_q   <= db_d;
      rise_q <= rise_d;
    end
  end

  assign db   = db_q;
  assign rise = rise_q;

endmodule

// File: rtl/battleship_shot_ctrl.sv
// rtl/battleship_shot_ctrl.sv - game FSM, hit/miss maps and LED column scan
module battleship_shot_ctrl
  import battleship_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CYC = 16,
  parameter int SHOTS_MAX    = 24,
  parameter int BLINK_SCANS  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [0:63] ship_map,
  input  logic [2:0]  row,
  input  logic [2:0]  col,
  input  logic        fire_raw,
  input  logic        new_game,
  output logic [2:0]  scan_col,
  output logic [0:7]  out_r,
  output logic [0:7]  out_g,
  output logic [5:0]  shots_left,
  output logic [6:0]  hits,
  output logic        shot_hit,
  output logic        shot_miss,
  output logic        shot_dup,
  output logic        game_over,
  output logic        game_won
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int BW = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;

  logic fire_db, fire_evt;

  battleship_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_fire_db (
    .clk  (clk),
    .rst  (rst),
    .din  (fire_raw),
    .db   (fire_db),
    .rise (fire_evt)
  );

  state_e        state_q, state_d;
  logic [0:63]   shot_q, shot_d;
  logic [0:63]   hit_q, hit_d;
  logic [0:63]   ship_q, ship_d;
  logic [5:0]    shots_q, shots_d;
  logic [6:0]    hits_q, hits_d;
  logic [6:0]    total_q, total_d;
  logic [5:0]    cell_q, cell_d;
  logic          hit_p_q, hit_p_d;
  logic          miss_p_q, miss_p_d;
  logic          dup_p_q, dup_p_d;
  logic          over_q, over_d;
  logic          won_q, won_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    col_q, col_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          phase_q, phase_d;
  logic [0:7]    r_q, r_d;
  logic [0:7]    g_q, g_d;
  logic [6:0]    ship_pop;

  always_comb begin
    ship_pop = '0;
    for (int i = 0; i < ROWS * COLS; i++) begin
      ship_pop = ship_pop + 7'(ship_map[i]);
    end
  end

  always_comb begin
    state_d  = state_q;
    shot_d   = shot_q;
    hit_d    = hit_q;
    ship_d   = ship_q;
    shots_d  = shots_q;
    hits_d   = hits_q;
    total_d  = total_q;
    cell_d   = cell_q;
    hit_p_d  = 1'b0;
    miss_p_d = 1'b0;
    dup_p_d  = 1'b0;
    over_d   = over_q;
    won_d    = won_q;
    if (new_game) begin
      shot_d  = '0;
      hit_d   = '0;
      ship_d  = ship_map;
      shots_d = 6'(SHOTS_MAX);
      hits_d  = '0;
      total_d = ship_pop;
      over_d  = 1'b0;
      won_d   = 1'b0;
      state_d = ST_PLAY;
    end else begin
      case (state_q)
        ST_PLAY: begin
          if (fire_evt) begin
            cell_d  = CELL_IDX(row, col);
            state_d = ST_EVAL;
          end
        end
        ST_EVAL: begin
          state_d = ST_WAIT_REL;
          if (shot_q[cell_q]) begin
            dup_p_d = 1'b1;
          end else begin
            shot_d[cell_q] = 1'b1;
            shots_d        = shots_q - 6'd1;
            if (ship_q[cell_q]) begin
              hit_d[cell_q] = 1'b1;
              hits_d        = hits_q + 7'd1;
              hit_p_d       = 1'b1;
            end else begin
              miss_p_d = 1'b1;
            end
          end
        end
        ST_WAIT_REL: begin
          // Win is tested first so a last-shot sink still counts as won.
          if (!fire_db) begin
            if (hits_q == total_q) begin
              state_d = ST_OVER;
              over_d  = 1'b1;
              won_d   = 1'b1;
            end else if (shots_q == 6'd0) begin
              state_d = ST_OVER;
              over_d  = 1'b1;
            end else begin
              state_d = ST_PLAY;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    presc_d = presc_q + 1'b1;
    col_d   = col_q;
    bcnt_d  = bcnt_q;
    phase_d = phase_q;
    r_d     = r_q;
    g_d     = g_q;
    if (presc_q == PW'(SCAN_DIV - 1)) begin
      presc_d = '0;
      col_d   = col_q + 3'd1;
      if (col_q == 3'(COLS - 1)) begin
        if (bcnt_q == BW'(BLINK_SCANS - 1)) begin
          bcnt_d  = '0;
          phase_d = ~phase_q;
        end else begin
          bcnt_d = bcnt_q + 1'b1;
        end
      end
      for (int r = 0; r < ROWS; r++) begin
        r_d[r] = hit_q[CELL_IDX(3'(r), col_d)];
        g_d[r] = shot_q[CELL_IDX(3'(r), col_d)] & ~hit_q[CELL_IDX(3'(r), col_d)];
      end
      // Cursor blink overlays the new column while a game is live.
      if (phase_d && (col_d == col) && (state_q inside {ST_PLAY, ST_EVAL, ST_WAIT_REL})) begin
        r_d[row] = 1'b1;
        g_d[row] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      shot_q   <= '0;
      hit_q    <= '0;
      ship_q   <= '0;
      shots_q  <= 6'(SHOTS_MAX);
      hits_q   <= '0;
      total_q  <= '0;
      cell_q   <= '0;
      hit_p_q  <= 1'b0;
      miss_p_q <= 1'b0;
      dup_p_q  <= 1'b0;
      over_q   <= 1'b0;
      won_q    <= 1'b0;
      presc_q  <= '0;
      col_q    <= '0;
      bcnt_q   <= '0;
      phase_q  <= 1'b0;
      r_q      <= '0;
      g_q      <= '0;
    end else begin
      state_q  <= state_d;
      shot_q   <= shot_d;
      hit_q    <= hit_d;
      ship_q   <= ship_d;
      shots_q  <= shots_d;
      hits_q   <= hits_d;
      total_q  <= total_d;
      cell_q   <= cell_d;
      hit_p_q  <= hit_p_d;
      miss_p_q <= miss_p_d;
      dup_p_q  <= dup_p_d;
      over_q   <= over_d;
      won_q    <= won_d;
      presc_q  <= presc_d;
      col_q    <= col_d;
      bcnt_q   <= bcnt_d;
      phase_q  <= phase_d;
      r_q      <= r_d;
      g_q      <= g_d;
    end
  end

  assign scan_col   = col_q;
  assign out_r      = r_q;
  assign out_g      = g_q;
  assign shots_left = shots_q;
  assign hits       = hits_q;
  assign shot_hit   = hit_p_q;
  assign shot_miss  = miss_p_q;
  assign shot_dup   = dup_p_q;
  assign game_over  = over_q;
  assign game_won   = won_q;

endmodule
